// File: rtl/tspi_pkg.sv
// Shared types and constants for the tspi SPI controller.
package tspi_pkg;

  localparam int unsigned TspiDivWidth = 16;
  localparam int unsigned TspiLenWidth = 6;

  // Serial-clock generator frame states.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StTrail
  } sclk_state_e;

  // Per-frame configuration captured when a frame is accepted.
  typedef struct packed {
    logic [TspiDivWidth-1:0] div;
    logic                    cpol;
    logic                    cpha;
    logic [TspiLenWidth-1:0] len;
  } sclk_cfg_t;

endpackage

// File: rtl/tspi_clkdiv.sv
// Loadable half-period divider: counts 0..div_i and pulses tick_o on the terminal count.
module tspi_clkdiv #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [Width-1:0] div_i,
  output logic             tick_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Clear dominates, so a tick can never fire in a cycle the owner is resetting the count.
  assign tick_o = enable_i & ~clear_i & (cnt_q == div_i);

  // Count up while enabled; wrap to zero on the terminal count so cnt_q never exceeds div_i.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tspi_sclk_gen.sv
// SPI serial-clock generator: produces sclk for all CPOL/CPHA modes plus registered
// sample/shift strobes aligned with the sclk edge, and a start/done/abort handshake.
module tspi_sclk_gen
  import tspi_pkg::*;
#(
  parameter int unsigned DivWidth = TspiDivWidth,
  parameter int unsigned LenWidth = TspiLenWidth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DivWidth-1:0] div_i,
  input  logic                cpol_i,
  input  logic                cpha_i,
  input  logic [LenWidth-1:0] len_i,
  input  logic                start_i,
  input  logic                abort_i,
  output logic                ready_o,
  output logic                sclk_o,
  output logic                sample_o,
  output logic                shift_o,
  output logic                done_o
);

  // Two edges per bit, up to 2^LenWidth bits, so two extra bits hold 2*(len+1) without overflow.
  localparam int unsigned EdgeWidth = LenWidth + 2;

  sclk_state_e state_q, state_d;

  logic [DivWidth-1:0]  div_q, div_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [EdgeWidth-1:0] edge_q, edge_d;
  logic                 sclk_q, sclk_d;
  logic                 sample_q, sample_d;
  logic                 shift_q, shift_d;
  logic                 done_q, done_d;

  logic                 div_clear;
  logic                 div_en;
  logic                 div_tick;
  logic [EdgeWidth-1:0] edge_num;
  logic [EdgeWidth-1:0] edge_total;
  logic                 leading;
  logic                 final_edge;

  // The divider is parked at zero while idle and restarted on abort, so every frame and the
  // trailing half-period begin from a clean count.
  assign div_clear = (state_q == StIdle) | abort_i;
  assign div_en    = (state_q != StIdle);

  tspi_clkdiv #(
    .Width(DivWidth)
  ) u_clkdiv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (div_clear),
    .enable_i(div_en),
    .div_i   (div_q),
    .tick_o  (div_tick)
  );

  // Edge bookkeeping: edges are numbered from 1, odd numbers are leading edges.
  assign edge_num   = edge_q + EdgeWidth'(1);
  assign edge_total = {1'b0, len_q, 1'b0} + EdgeWidth'(2);
  assign leading    = edge_num[0];
  assign final_edge = (edge_num == edge_total);

  // Next-state, config capture, sclk toggling and strobe decode.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    len_d    = len_q;
    edge_d   = edge_q;
    sclk_d   = sclk_q;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    done_d   = 1'b0;

    if (abort_i) begin
      // Abort beats everything, including a start presented in the same cycle.
      state_d = StIdle;
      sclk_d  = cpol_q;
      edge_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Track the idle level so sclk already rests at the right polarity before a frame.
          sclk_d = cpol_i;
          edge_d = '0;
          if (start_i) begin
            div_d   = div_i;
            cpol_d  = cpol_i;
            cpha_d  = cpha_i;
            len_d   = len_i;
            state_d = StRun;
          end
        end

        StRun: begin
          if (div_tick) begin
            sclk_d = ~sclk_q;
            edge_d = edge_num;
            if (leading) begin
              if (cpha_q) shift_d = 1'b1;
              else        sample_d = 1'b1;
            end else begin
              // With cpha=0 the first bit is already on the line at start, so the final
              // trailing edge has no further bit to shift out.
              if (cpha_q) sample_d = 1'b1;
              else        shift_d  = ~final_edge;
            end
            if (final_edge) state_d = StTrail;
          end
        end

        StTrail: begin
          sclk_d = cpol_q;
          if (div_tick) begin
            done_d  = 1'b1;
            edge_d  = '0;
            state_d = StIdle;
          end
        end

        default: begin
          state_d = StIdle;
          sclk_d  = cpol_q;
          edge_d  = '0;
        end
      endcase
    end
  end

  // State, configuration and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      div_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      len_q    <= '0;
      edge_q   <= '0;
      sclk_q   <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      len_q    <= len_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
    end
  end

  // ready_o comes straight from the state so it rises together with done_o.
  assign ready_o  = (state_q == StIdle);
  assign sclk_o   = sclk_q;
  assign sample_o = sample_q;
  assign shift_o  = shift_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_tspi_sclk_gen.sv
// Directed bench for tspi_sclk_gen: event times are logged relative to the start acceptance
// edge (cycle 0) and compared against hand-computed schedules.
module tb_tspi_sclk_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] div = '0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic [5:0]  len = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ready, sclk, sample, shift, done;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  int mon_rel;
  logic sclk_prev = 1'b0;
  int rise_q[$], fall_q[$], samp_q[$], shft_q[$], done_t[$];

  tspi_sclk_gen #(
    .DivWidth(16),
    .LenWidth(6)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .div_i   (div),
    .cpol_i  (cpol),
    .cpha_i  (cpha),
    .len_i   (len),
    .start_i (start),
    .abort_i (abort),
    .ready_o (ready),
    .sclk_o  (sclk),
    .sample_o(sample),
    .shift_o (shift),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event logger, sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon_rel = cyc - t0;
    if (sclk !== sclk_prev) begin
      if (sclk) rise_q.push_back(mon_rel);
      else      fall_q.push_back(mon_rel);
    end
    sclk_prev = sclk;
    if (sample) samp_q.push_back(mon_rel);
    if (shift)  shft_q.push_back(mon_rel);
    if (done)   done_t.push_back(mon_rel);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rise_q.delete();
    fall_q.delete();
    samp_q.delete();
    shft_q.delete();
    done_t.delete();
    sclk_prev = sclk;
  endtask

  // Call in the low clock phase; returns just after the acceptance edge (cycle 0).
  task automatic start_frame(input logic [15:0] d, input logic p, input logic h,
                             input logic [5:0] l, input bit hold);
    check_eq("ready_before_start", ready, 1);
    div   = d;
    cpol  = p;
    cpha  = h;
    len   = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    clear_log();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (done !== 1'b1) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values.
    #12;
    check_eq("rst_ready", ready, 1);
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_sample", sample, 0);
    check_eq("rst_shift", shift, 0);
    check_eq("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 0: div=1, len=7.
    start_frame(16'd1, 1'b0, 1'b0, 6'd7, 1'b0);
    wait_done(60, "m0");
    check_eq("m0_rise_n", rise_q.size(), 8);
    check_eq("m0_fall_n", fall_q.size(), 8);
    check_eq("m0_samp_n", samp_q.size(), 8);
    check_eq("m0_shft_n", shft_q.size(), 7);
    for (int k = 0; k < 8; k++) begin
      check_eq("m0_rise_t", rise_q[k], 2 + 4 * k);
      check_eq("m0_fall_t", fall_q[k], 4 + 4 * k);
      check_eq("m0_samp_t", samp_q[k], 2 + 4 * k);
    end
    for (int k = 0; k < 7; k++) check_eq("m0_shft_t", shft_q[k], 4 + 4 * k);
    check_eq("m0_done_t", done_t[0], 34);
    check_eq("m0_ready_at_done", ready, 1);
    @(negedge clk);
    #1;
    check_eq("m0_done_single", done, 0);

    // Mode 3: div=0, len=3, sclk idles high.
    cpol = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("m3_idle_sclk", sclk, 1);
    start_frame(16'd0, 1'b1, 1'b1, 6'd3, 1'b0);
    wait_done(30, "m3");
    check_eq("m3_fall_n", fall_q.size(), 4);
    check_eq("m3_rise_n", rise_q.size(), 4);
    check_eq("m3_shft_n", shft_q.size(), 4);
    check_eq("m3_samp_n", samp_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check_eq("m3_fall_t", fall_q[k], 1 + 2 * k);
      check_eq("m3_shft_t", shft_q[k], 1 + 2 * k);
      check_eq("m3_samp_t", samp_q[k], 2 + 2 * k);
    end
    check_eq("m3_done_t", done_t[0], 9);
    check_eq("m3_rest_sclk", sclk, 1);
    cpol = 1'b0;
    repeat (2) @(negedge clk);

    // Single-bit frame with a long half-period.
    start_frame(16'h0FFF, 1'b0, 1'b0, 6'd0, 1'b0);
    wait_done(13000, "len0");
    check_eq("len0_rise_n", rise_q.size(), 1);
    check_eq("len0_rise_t", rise_q[0], 4096);
    check_eq("len0_fall_t", fall_q[0], 8192);
    check_eq("len0_samp_n", samp_q.size(), 1);
    check_eq("len0_shft_n", shft_q.size(), 0);
    check_eq("len0_done_t", done_t[0], 12288);

    // Maximum frame length: 128 edges.
    @(negedge clk);
    start_frame(16'd0, 1'b0, 1'b0, 6'd63, 1'b0);
    wait_done(200, "len63");
    check_eq("len63_rise_n", rise_q.size(), 64);
    check_eq("len63_fall_n", fall_q.size(), 64);
    check_eq("len63_last_fall", fall_q[63], 128);
    check_eq("len63_samp_n", samp_q.size(), 64);
    check_eq("len63_shft_n", shft_q.size(), 63);
    check_eq("len63_done_t", done_t[0], 129);

    // Full-width divisor: no edge long after a narrow compare would have fired; then abort.
    @(negedge clk);
    start_frame(16'hFFFF, 1'b0, 1'b0, 6'd0, 1'b0);
    repeat (300) @(negedge clk);
    #1;
    check_eq("wide_no_edge", rise_q.size(), 0);
    check_eq("wide_no_samp", samp_q.size(), 0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check_eq("wide_abort_ready", ready, 1);
    @(negedge clk);

    // Abort sampled at edge 10 of a mode-0 frame, restart at edge 12.
    start_frame(16'd1, 1'b0, 1'b0, 6'd7, 1'b0);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check_eq("ab_rise_n", rise_q.size(), 2);
    check_eq("ab_samp_n", samp_q.size(), 2);
    check_eq("ab_shft_n", shft_q.size(), 2);
    check_eq("ab_sclk10", sclk, 0);
    check_eq("ab_ready10", ready, 1);
    @(negedge clk);
    #1;
    check_eq("ab_sclk11", sclk, 0);
    check_eq("ab_samp_n11", samp_q.size(), 2);
    check_eq("ab_no_done", done_t.size(), 0);
    start_frame(16'd1, 1'b0, 1'b0, 6'd7, 1'b0);
    check_eq("ab_restart_busy", ready, 0);
    wait_done(60, "ab_restart");
    check_eq("ab_restart_rise0", rise_q[0], 2);
    check_eq("ab_restart_done", done_t[0], 34);
    @(negedge clk);

    // Input isolation and back-to-back frames with start_i held high.
    start_frame(16'd1, 1'b0, 1'b0, 6'd7, 1'b1);
    repeat (6) @(negedge clk);
    div  = 16'd5;
    cpol = 1'b1;
    cpha = 1'b1;
    len  = 6'd2;
    repeat (15) @(negedge clk);
    div  = 16'd1;
    cpol = 1'b0;
    cpha = 1'b0;
    len  = 6'd7;
    wait_done(40, "iso");
    check_eq("iso_done_t", done_t[0], 34);
    check_eq("iso_rise_n", rise_q.size(), 8);
    check_eq("iso_last_rise", rise_q[7], 30);
    check_eq("iso_samp_n", samp_q.size(), 8);
    check_eq("iso_shft_n", shft_q.size(), 7);
    check_eq("iso_ready_at_done", ready, 1);
    @(negedge clk);
    #1;
    check_eq("b2b_accepted", ready, 0);
    wait_done(60, "b2b");
    start = 1'b0;
    check_eq("b2b_first_rise", rise_q[8], 37);
    check_eq("b2b_done_t", done_t[1], 69);
    @(negedge clk);

    // Asynchronous reset while sclk is high and a sample strobe is active.
    start_frame(16'd1, 1'b0, 1'b0, 6'd7, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("prerst_sclk", sclk, 1);
    check_eq("prerst_sample", sample, 1);
    rst = 1'b1;
    #1;
    check_eq("midrst_sclk", sclk, 0);
    check_eq("midrst_ready", ready, 1);
    check_eq("midrst_sample", sample, 0);
    check_eq("midrst_shift", shift, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check_eq("postrst_samp_n", samp_q.size(), 1);
    check_eq("postrst_no_done", done_t.size(), 0);
    check_eq("postrst_ready", ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tspi_sclk_gen.md
Name: tspi_sclk_gen

Overview:
- Parametrised SPI serial-clock generator for the tspi controller; successor to the fixed 8-bit baud divider.
- Adds a wide divisor, all four CPOL/CPHA modes and a frame length in bits.
- Adds per-edge sample/shift strobes, a start/done handshake and abort.
- Sits between the tspi register/control FSM and the shift-register datapath; the datapath acts only on this block's strobes.

Parameters:
- DivWidth, 16, width of half-period divisor; half-period = div_i+1 clk_i cycles.
- LenWidth, 6, width of frame-length field; frame = len_i+1 bits (1..2^LenWidth).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- div_i  in  DivWidth  half-period divisor minus one; sampled on start
- cpol_i  in  1  clock idle level; tracked while idle, latched on start
- cpha_i  in  1  0: sample leading/shift trailing; 1: shift leading/sample trailing
- len_i  in  LenWidth  frame bits minus one; sampled on start
- start_i  in  1  request new frame; accepted when start_i & ready_o
- abort_i  in  1  terminate frame immediately
- ready_o  out  1  idle, can accept start
- sclk_o  out  1  serial clock (registered, glitch-free)
- sample_o  out  1  one-cycle pulse: datapath samples MISO
- shift_o  out  1  one-cycle pulse: datapath drives next MOSI bit
- done_o  out  1  one-cycle pulse: frame completed normally

Behaviour:
- Reset values:
  - Outputs: ready_o=1, sclk_o=0, all strobes=0.
  - State: FSM=IDLE, counters=0.
- FSM states:
  - IDLE -> RUN on accepted start.
  - RUN -> TRAIL after the final edge.
  - TRAIL -> IDLE after one half-period.
  - Any state -> IDLE on abort_i.
- IDLE:
  - ready_o=1.
  - sclk_o register loads cpol_i every cycle.
  - Divider and edge counter are held at 0.
- Start acceptance cycle: latch div_i, cpol_i, cpha_i, len_i into *_q; clear divider; ready_o=0 from next cycle.
- Inputs are ignored while busy: configuration changes and start_i have no effect outside IDLE.
- RUN:
  - Divider increments each cycle.
  - When divider==div_q: divider clears, sclk_o toggles, edge counter increments.
  - Total edges = 2*(len_q+1); edge counter width LenWidth+2.
- Edge numbering from 1. Odd edges are leading, even edges are trailing.
  - cpha_q=0: sample_o on every leading edge; shift_o on trailing edges except the final edge. The first bit is presented by the datapath at start.
  - cpha_q=1: shift_o on every leading edge; sample_o on every trailing edge.
- Strobe timing: strobes are registered and asserted in the same cycle sclk_o first shows the new level.
- Per-frame pulse counts:
  - sample_o: always len+1.
  - shift_o: len for cpha=0; len+1 for cpha=1.
- Latency: the first sclk_o edge appears div_q+1 cycles after the start acceptance edge.
- div=0 is legal: sclk frequency = clk/2.
- TRAIL:
  - sclk_o rests at cpol_q; no strobes.
  - Waits div_q+1 cycles, then done_o pulses one cycle.
  - ready_o=1 in the same cycle as done_o.
- abort_i (highest priority, any state):
  - Next cycle: FSM=IDLE, sclk_o=cpol_q, strobes=0, no done_o.
  - An abort in the start cycle wins: the start is dropped.
- Simultaneous done and start: start_i in the done_o cycle is accepted (ready_o=1), so back-to-back frames are allowed.
- Reset mid-frame: asynchronous return to reset values; no pulses generated.
- Divider compare is unsigned and full-width, with no wrap: the divider never exceeds div_q.

Decomposition:
- tspi_pkg additions:
  - sclk_state_e (IDLE, RUN, TRAIL).
  - sclk_cfg_t struct {div, cpol, cpha, len} sized from package localparams TspiDivWidth=16, TspiLenWidth=6.
- One sub-module, tspi_clkdiv: a loadable half-period divider.
  - Inputs: clear, enable, div.
  - Output: tick pulse when count==div.
  - It is reused by the future CS-setup/hold timer.

Test Plan:
- Mode 0 (div=1, len=7, cpol=0, cpha=0), start at cycle 0:
  - Rising edges at cycles 2,6,…,30; falling edges at 4,…,32.
  - 8 sample_o pulses on rising edges; 7 shift_o pulses on falling edges 4..28.
  - done_o and ready_o at cycle 34.
- Mode 3 (div=0, len=3, cpol=1, cpha=1):
  - sclk idles high and toggles every cycle.
  - 4 shift_o pulses on falling edges, 4 sample_o pulses on rising edges.
  - 8 edges, done_o 1 cycle after the last edge.
- Edge-count extremes:
  - len=0, div=0xFFFF: exactly 2 edges 65536 cycles apart, 1 sample, done.
  - len=63: 128 edges counted without overflow.
- Abort at cycle 10 of a mode-0, div=1, len=7 frame: sclk_o=0 at cycle 11, no further strobes, no done_o; a new start at cycle 12 is accepted.
- Input isolation:
  - Changing div_i/cpol_i and pulsing start_i mid-frame: no effect on timing.
  - start_i held high across done_o: second frame begins with the same latency.
- Reset asserted mid-RUN: sclk_o=0, ready_o=1 immediately (asynchronous); strobes low.
